// File: rtl/pmod_acl2_spi_responder.sv
// ADXL362-style SPI responder (mode 0) for the PMOD ACL2: 0x0A write / 0x0B read,
// 64-byte register map, STATUS/INTMAP driven interrupts and a read snapshot of the sample.
//
// state     | meaning
// ST_IDLE   | csn high, waiting for a transfer
// ST_CMD    | receiving the command byte
// ST_ADDR   | receiving the register address
// ST_IGNORE | unknown command, discard bytes until csn rises
// ST_WDATA  | write burst, one register per byte
// ST_RDATA  | read burst, one register per byte
module pmod_acl2_spi_responder #(
  parameter int          parm_sync_stages = 2,
  parameter logic [7:0]  parm_devid_ad    = 8'hAD
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz_n,
  input  logic        ei_sck,
  input  logic        ei_csn,
  input  logic        ei_copi,
  output logic        eo_cipo_o,
  output logic        eo_cipo_t,
  output logic        eo_int1,
  output logic        eo_int2,
  input  logic [63:0] i_data_3axis_temp,
  input  logic        i_data_valid,
  input  logic        i_evt_act,
  input  logic        i_evt_inact,
  output logic        o_reg_wr,
  output logic [5:0]  o_reg_wr_addr,
  output logic [7:0]  o_reg_wr_data
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_IGNORE = 3'd3;
  localparam logic [2:0] ST_WDATA  = 3'd4;
  localparam logic [2:0] ST_RDATA  = 3'd5;

  logic [parm_sync_stages-1:0] sck_sync, csn_sync, copi_sync;
  logic       sck_s, csn_s, copi_s, sck_d, csn_d;
  logic       sck_rise, csn_fall, csn_rise, byte_done;
  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte;
  logic [7:0] tx_sr;
  logic       is_read;
  logic [5:0] addr;
  logic [5:0] rd_cur;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] status, stat_n;
  logic       soft_rst_now;
  logic       wr_in_range;
  logic [7:0] wr_regs [16];
  logic [7:0] shadow  [8];
  logic [7:0] snap    [8];

  assign sck_s  = sck_sync[parm_sync_stages-1];
  assign csn_s  = csn_sync[parm_sync_stages-1];
  assign copi_s = copi_sync[parm_sync_stages-1];

  assign sck_rise  = sck_s & ~sck_d;
  assign csn_fall  = ~csn_s & csn_d;
  assign csn_rise  = csn_s & ~csn_d;
  assign rx_byte   = {rx_sr, copi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);

  assign eo_cipo_o = (state == ST_RDATA) & tx_sr[7];
  assign eo_cipo_t = csn_s;

  assign soft_rst_now = csn_rise && (wr_regs[0] == 8'h52);
  assign wr_in_range  = (addr >= 6'h1F) && (addr <= 6'h2E);

  // The address byte itself selects the first read register, later bytes use the counter.
  assign rd_addr = (state == ST_ADDR) ? rx_byte[5:0] : addr;

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr == 6'h00)                              rd_data = parm_devid_ad;
    else if (rd_addr == 6'h01)                         rd_data = 8'h1D;
    else if (rd_addr == 6'h02)                         rd_data = 8'hF2;
    else if (rd_addr == 6'h03)                         rd_data = 8'h01;
    else if (rd_addr == 6'h0B)                         rd_data = status;
    else if (rd_addr >= 6'h0E && rd_addr <= 6'h15)     rd_data = snap[3'(rd_addr[2:0] + 3'd2)];
    else if (rd_addr >= 6'h1F && rd_addr <= 6'h2E)     rd_data = wr_regs[4'(rd_addr[3:0] + 4'd1)];
  end

  // Clears are applied before sets so a same-cycle event is never lost.
  always_comb begin
    stat_n = status;
    if (soft_rst_now) stat_n = 8'h00;
    if (byte_done && state == ST_RDATA && rd_cur == 6'h0B) stat_n[5:4] = 2'b00;
    if (byte_done && state == ST_RDATA && rd_cur == 6'h15) stat_n[0] = 1'b0;
    if (i_data_valid) stat_n[0] = 1'b1;
    if (i_evt_act) begin
      stat_n[4] = 1'b1;
      stat_n[6] = 1'b1;
    end
    if (i_evt_inact) begin
      stat_n[5] = 1'b1;
      stat_n[6] = 1'b0;
    end
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rst_20mhz_n) begin
      sck_sync      <= '0;
      csn_sync      <= '1;
      copi_sync     <= '0;
      sck_d         <= 1'b0;
      csn_d         <= 1'b1;
      state         <= ST_IDLE;
      bit_cnt       <= 3'd0;
      rx_sr         <= 7'd0;
      tx_sr         <= 8'd0;
      is_read       <= 1'b0;
      addr          <= 6'd0;
      rd_cur        <= 6'd0;
      status        <= 8'd0;
      eo_int1       <= 1'b0;
      eo_int2       <= 1'b0;
      o_reg_wr      <= 1'b0;
      o_reg_wr_addr <= 6'd0;
      o_reg_wr_data <= 8'd0;
      for (int i = 0; i < 16; i++) wr_regs[i] <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 8'h00;
        snap[i]   <= 8'h00;
      end
    end else begin
      sck_sync  <= {sck_sync[parm_sync_stages-2:0], ei_sck};
      csn_sync  <= {csn_sync[parm_sync_stages-2:0], ei_csn};
      copi_sync <= {copi_sync[parm_sync_stages-2:0], ei_copi};
      sck_d     <= sck_s;
      csn_d     <= csn_s;
      o_reg_wr  <= 1'b0;
      status    <= stat_n;
      eo_int1   <= (|(status[6:0] & wr_regs[11][6:0])) ^ wr_regs[11][7];
      eo_int2   <= (|(status[6:0] & wr_regs[12][6:0])) ^ wr_regs[12][7];

      if (i_data_valid)
        for (int i = 0; i < 8; i++) shadow[i] <= i_data_3axis_temp[63-8*i -: 8];

      if (csn_fall) begin
        state   <= ST_CMD;
        bit_cnt <= 3'd0;
        tx_sr   <= 8'd0;
        for (int i = 0; i < 8; i++) snap[i] <= shadow[i];
      end else if (csn_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
        tx_sr   <= 8'd0;
        if (soft_rst_now)
          for (int i = 0; i < 16; i++) wr_regs[i] <= 8'h00;
      end else if (state != ST_IDLE && sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte[6:0];
        tx_sr   <= {tx_sr[6:0], 1'b0};
        if (bit_cnt == 3'd7) begin
          case (state)
            ST_CMD: begin
              is_read <= (rx_byte == 8'h0B);
              state   <= (rx_byte == 8'h0A || rx_byte == 8'h0B) ? ST_ADDR : ST_IGNORE;
            end
            ST_ADDR: begin
              if (is_read) begin
                state  <= ST_RDATA;
                tx_sr  <= rd_data;
                rd_cur <= rx_byte[5:0];
                addr   <= rx_byte[5:0] + 6'd1;
              end else begin
                state <= ST_WDATA;
                addr  <= rx_byte[5:0];
              end
            end
            ST_WDATA: begin
              if (wr_in_range) begin
                wr_regs[4'(addr[3:0] + 4'd1)] <= rx_byte;
                o_reg_wr      <= 1'b1;
                o_reg_wr_addr <= addr;
                o_reg_wr_data <= rx_byte;
              end
              addr <= addr + 6'd1;
            end
            ST_RDATA: begin
              tx_sr  <= rd_data;
              rd_cur <= addr;
              addr   <= addr + 6'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
